bbc_host_bus_responder: RTL and testbench

//  Host-side end of the 6502 CPU-socket interface: plays the host machine's role towards the accelerator.

---
 rtl/bbc_host_bus_responder.sv | 173 +++++++++++++++++
 tb/tb_bbc_host_bus_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbc_host_bus_responder.sv
// bbc_host_bus_responder
//   Host end of the 6502 CPU-socket interface. It generates phi0 from hsclk,
//   samples the accelerator's address/rnw/sync at the end of phase 1, stretches
//   phase 2 for addresses in the slow I/O window, and bridges each bus cycle to
//   a simple memory port. It also drives rdy for host-requested read waits.
// Ports
//   hsclk, reset           : clock, synchronous active-high reset
//   bbc_phi0               : generated phi0 (0 = phase 1, 1 = phase 2)
//   bbc_a/rnw/sync/d_in    : bus inputs from the accelerator
//   bbc_d_out/bbc_d_oe     : read data and its drive enable towards the accelerator
//   rdy                    : 0 while the current read is a wait cycle
//   host_wait              : host request to turn the current read into a wait
//   mem_addr/rd/rdata/wr/wdata : memory port (rdata valid one hsclk after mem_rd)
//   sync_addr              : address of the last completed opcode fetch
//   slow_cycle             : high for the whole phase 2 of a stretched cycle
module bbc_host_bus_responder #(
  parameter int unsigned DIVIDE     = 4,
  parameter logic [15:0] SLOW_LO    = 16'hFC00,
  parameter logic [15:0] SLOW_HI    = 16'hFEFF,
  parameter int unsigned SLOW_EXTRA = 8
) (
  input  logic        hsclk,
  input  logic        reset,
  output logic        bbc_phi0,
  input  logic [15:0] bbc_a,
  input  logic        bbc_rnw,
  input  logic        bbc_sync,
  input  logic [7:0]  bbc_d_in,
  output logic [7:0]  bbc_d_out,
  output logic        bbc_d_oe,
  output logic        rdy,
  input  logic        host_wait,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic [15:0] sync_addr,
  output logic        slow_cycle
);

  localparam int unsigned CW = $clog2(DIVIDE + SLOW_EXTRA);
  localparam logic [CW-1:0] FAST_LAST = CW'(DIVIDE - 1);
  localparam logic [CW-1:0] SLOW_LAST = CW'(DIVIDE + SLOW_EXTRA - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {PH1, PH2} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phi0_q, phi0_d;
  logic          rnw_q, rnw_d;
  logic          sync_q, sync_d;
  logic          slow_q, slow_d;
  logic          wait_q, wait_d;
  logic          rdy_q, rdy_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          oe_q, oe_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   sync_addr_q, sync_addr_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wait_req;
  logic          good_read;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    phi0_d      = phi0_q;
    rnw_d       = rnw_q;
    sync_d      = sync_q;
    slow_d      = slow_q;
    wait_d      = wait_q;
    rdy_d       = rdy_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    oe_d        = oe_q;
    addr_d      = addr_q;
    sync_addr_d = sync_addr_q;
    dout_d      = dout_q;
    wdata_d     = wdata_q;
    wait_req    = host_wait & bbc_rnw;
    good_read   = rnw_q & ~wait_q;

    unique case (state_q)
      PH1: begin
        if (cnt_q == FAST_LAST) begin
          state_d = PH2;
          cnt_d   = '0;
          phi0_d  = 1'b1;
          addr_d  = bbc_a;
          rnw_d   = bbc_rnw;
          sync_d  = bbc_sync;
          slow_d  = (bbc_a >= SLOW_LO) && (bbc_a <= SLOW_HI);
          wait_d  = wait_req;
          rdy_d   = ~wait_req;
          rd_d    = bbc_rnw & ~wait_req;
        end
      end
      PH2: begin
        // Memory answers one hsclk after the strobe, so data is captured at the
        // end of PH2 cycle 1 while the enable already rises at cycle 1.
        if (cnt_q == '0 && good_read) oe_d = 1'b1;
        if (cnt_q == CNT_ONE && good_read) dout_d = mem_rdata;
        if (cnt_q == (slow_q ? SLOW_LAST : FAST_LAST)) begin
          state_d = PH1;
          cnt_d   = '0;
          phi0_d  = 1'b0;
          oe_d    = 1'b0;
          if (!rnw_q) begin
            wdata_d = bbc_d_in;
            wr_d    = 1'b1;
          end else if (sync_q && !wait_q) begin
            sync_addr_d = addr_q;
          end
        end
      end
      default: begin
        state_d = PH1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge hsclk) begin
    if (reset) begin
      state_q     <= PH1;
      cnt_q       <= '0;
      phi0_q      <= 1'b0;
      rnw_q       <= 1'b0;
      sync_q      <= 1'b0;
      slow_q      <= 1'b0;
      wait_q      <= 1'b0;
      rdy_q       <= 1'b1;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      sync_addr_q <= '0;
      dout_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phi0_q      <= phi0_d;
      rnw_q       <= rnw_d;
      sync_q      <= sync_d;
      slow_q      <= slow_d;
      wait_q      <= wait_d;
      rdy_q       <= rdy_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      sync_addr_q <= sync_addr_d;
      dout_q      <= dout_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bbc_phi0   = phi0_q;
  assign bbc_d_out  = dout_q;
  assign bbc_d_oe   = oe_q;
  assign rdy        = rdy_q;
  assign mem_addr   = addr_q;
  assign mem_rd     = rd_q;
  assign mem_wr     = wr_q;
  assign mem_wdata  = wdata_q;
  assign sync_addr  = sync_addr_q;
  assign slow_cycle = slow_q & (state_q == PH2);

endmodule

// File: tb/tb_bbc_host_bus_responder.sv
// Bench for bbc_host_bus_responder: a host memory model answers mem_rd, a
// monitor logs memory strobes, and each test task pushes expected memory
// transactions when it drives a bus cycle and pops them against the log.
module tb_bbc_host_bus_responder;

  logic        hsclk = 1'b0;
  logic        reset = 1'b1;
  logic        bbc_phi0;
  logic [15:0] bbc_a = '0;
  logic        bbc_rnw = 1'b0;
  logic        bbc_sync = 1'b0;
  logic [7:0]  bbc_d_in = '0;
  logic [7:0]  bbc_d_out;
  logic        bbc_d_oe;
  logic        rdy;
  logic        host_wait = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = '0;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [15:0] sync_addr;
  logic        slow_cycle;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [7:0] mem [logic [15:0]];

  // Per-step records of one bus cycle, index k = negedges after PH1 start.
  logic [31:0] v_phi0, v_rd, v_wr, v_oe, v_slow, v_rdy;
  logic [15:0] a_addr [32];
  logic [15:0] a_sync [32];
  logic [7:0]  a_dout [32];

  bbc_host_bus_responder #(
    .DIVIDE(4), .SLOW_LO(16'hFC00), .SLOW_HI(16'hFEFF), .SLOW_EXTRA(8)
  ) dut (
    .hsclk(hsclk), .reset(reset), .bbc_phi0(bbc_phi0), .bbc_a(bbc_a),
    .bbc_rnw(bbc_rnw), .bbc_sync(bbc_sync), .bbc_d_in(bbc_d_in),
    .bbc_d_out(bbc_d_out), .bbc_d_oe(bbc_d_oe), .rdy(rdy), .host_wait(host_wait),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .sync_addr(sync_addr), .slow_cycle(slow_cycle)
  );

  always #5 hsclk = ~hsclk;

  // Host memory: registered read, one hsclk latency.
  always @(posedge hsclk) begin
    if (mem_rd) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    if (mem_wr) mem[mem_addr] = mem_wdata;
  end

  always @(negedge hsclk) begin
    ev_t o;
    if (mem_rd) begin
      o = '{1'b0, mem_addr, 8'h00};
      obs_q.push_back(o);
    end
    if (mem_wr) begin
      o = '{1'b1, mem_addr, mem_wdata};
      obs_q.push_back(o);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge hsclk);
    #1;
  endtask

  function automatic logic [7:0] mem_peek(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic record(input int k);
    v_phi0[k] = bbc_phi0;
    v_rd[k]   = mem_rd;
    v_wr[k]   = mem_wr;
    v_oe[k]   = bbc_d_oe;
    v_slow[k] = slow_cycle;
    v_rdy[k]  = rdy;
    a_addr[k] = mem_addr;
    a_sync[k] = sync_addr;
    a_dout[k] = bbc_d_out;
  endtask

  // Waits for the falling edge of phi0, i.e. PH1 cycle 0.
  task automatic align();
    logic prev;
    prev = bbc_phi0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (prev === 1'b1 && bbc_phi0 === 1'b0) return;
      prev = bbc_phi0;
    end
    total++;
    bad++;
    $display("FAIL align: phi0 never fell within 64 cycles, required a falling edge");
  endtask

  // Drives one bus cycle from PH1 cycle 0 and records n further steps.
  task automatic run_bus(input logic [15:0] a, input logic rnw, input logic sy,
                         input logic [7:0] din, input logic hw, input int n);
    ev_t e;
    align();
    obs_q.delete();
    exp_q.delete();
    v_phi0 = '0; v_rd = '0; v_wr = '0; v_oe = '0; v_slow = '0; v_rdy = '0;
    bbc_a = a; bbc_rnw = rnw; bbc_sync = sy; bbc_d_in = din; host_wait = hw;
    if (rnw && !hw) begin
      e = '{1'b0, a, mem_peek(a)};
      exp_q.push_back(e);
    end else if (!rnw) begin
      e = '{1'b1, a, din};
      exp_q.push_back(e);
    end
    record(0);
    for (int k = 1; k <= n; k++) begin
      step();
      record(k);
    end
  endtask

  task automatic test_reset();
    logic [15:0] ph;
    reset = 1'b1;
    bbc_rnw = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if ({bbc_phi0, rdy, bbc_d_oe, mem_rd, mem_wr, slow_cycle} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_ctrl: phi0/rdy/oe/rd/wr/slow=%b required 010000",
               {bbc_phi0, rdy, bbc_d_oe, mem_rd, mem_wr, slow_cycle});
    end
    total++;
    if ({mem_addr, bbc_d_out, mem_wdata, sync_addr} !== 48'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h dout=%h wdata=%h sync=%h required all 0",
               mem_addr, bbc_d_out, mem_wdata, sync_addr);
    end
    reset = 1'b0;
    v_rdy = '0; v_oe = '0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      ph[k] = bbc_phi0;
      v_rdy[k] = rdy;
      v_oe[k] = bbc_d_oe;
    end
    total++;
    if (ph !== 16'hF0F0) begin
      bad++;
      $display("FAIL reset_phi0: phi0 sequence=%b required %b", ph, 16'hF0F0);
    end
    total++;
    if (v_rdy[15:0] !== 16'hFFFF || v_oe[15:0] !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rdy_oe: rdy=%h oe=%h required FFFF/0000", v_rdy[15:0], v_oe[15:0]);
    end
  endtask

  task automatic test_read();
    ev_t e, o;
    run_bus(16'h1234, 1'b1, 1'b0, 8'h00, 1'b0, 8);
    total++;
    if (v_rd[8:0] !== 9'b000010000 || a_addr[4] !== 16'h1234) begin
      bad++;
      $display("FAIL read_strobe: rd=%b addr=%h required 000010000/1234", v_rd[8:0], a_addr[4]);
    end
    total++;
    if (v_oe[8:0] !== 9'b011100000 || v_phi0[8:0] !== 9'b011110000) begin
      bad++;
      $display("FAIL read_oe: oe=%b phi0=%b required 011100000/011110000", v_oe[8:0], v_phi0[8:0]);
    end
    total++;
    if (exp_q.size() != 1 || obs_q.size() != 1) begin
      bad++;
      $display("FAIL read_sb: obs entries=%0d required %0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.wr !== e.wr || o.addr !== e.addr || a_dout[7] !== e.data) begin
        bad++;
        $display("FAIL read_sb: wr=%b addr=%h dout=%h required %b/%h/%h",
                 o.wr, o.addr, a_dout[7], e.wr, e.addr, e.data);
      end
    end
  endtask

  task automatic test_write();
    ev_t e, o;
    run_bus(16'h2000, 1'b0, 1'b0, 8'h5A, 1'b0, 9);
    total++;
    if (v_wr[9:0] !== 10'b0100000000 || v_rd[9:0] !== '0 || v_oe[9:0] !== '0) begin
      bad++;
      $display("FAIL write_strobe: wr=%b rd=%b oe=%b required 0100000000/0/0",
               v_wr[9:0], v_rd[9:0], v_oe[9:0]);
    end
    total++;
    if (exp_q.size() != 1 || obs_q.size() != 1) begin
      bad++;
      $display("FAIL write_sb: obs entries=%0d required %0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        bad++;
        $display("FAIL write_sb: wr=%b addr=%h data=%h required %b/%h/%h",
                 o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
  endtask

  task automatic test_slow_window();
    logic [15:0] addrs [3];
    int exp_len [3];
    int len, nslow;
    ev_t e, o;
    addrs = '{16'hFC00, 16'hFEFF, 16'hFF00};
    exp_len = '{12, 12, 4};
    for (int t = 0; t < 3; t++) begin
      run_bus(addrs[t], 1'b1, 1'b0, 8'h00, 1'b0, 5 + exp_len[t]);
      len = 0;
      nslow = 0;
      for (int k = 4; k <= 5 + exp_len[t] && v_phi0[k]; k++) len++;
      for (int k = 0; k <= 5 + exp_len[t]; k++) nslow += int'(v_slow[k]);
      total++;
      if (len != exp_len[t] || nslow != (exp_len[t] == 12 ? 12 : 0) || v_slow[3] !== 1'b0) begin
        bad++;
        $display("FAIL slow_%h: ph2 len=%0d slow cycles=%0d required %0d/%0d",
                 addrs[t], len, nslow, exp_len[t], (exp_len[t] == 12 ? 12 : 0));
      end
      total++;
      if (exp_q.size() != 1 || obs_q.size() != 1) begin
        bad++;
        $display("FAIL slow_sb_%h: obs entries=%0d required 1", addrs[t], obs_q.size());
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o.addr !== e.addr || a_dout[3 + exp_len[t]] !== e.data) begin
          bad++;
          $display("FAIL slow_sb_%h: addr=%h dout=%h required %h/%h",
                   addrs[t], o.addr, a_dout[3 + exp_len[t]], e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_wait();
    ev_t e, o;
    run_bus(16'h3000, 1'b1, 1'b0, 8'h00, 1'b1, 8);
    total++;
    if (v_rdy[7:4] !== 4'b0000 || v_rd[8:0] !== '0 || v_oe[8:0] !== '0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL wait_read: rdy=%b rd=%b oe=%b events=%0d required 0000/0/0/0",
               v_rdy[7:4], v_rd[8:0], v_oe[8:0], obs_q.size());
    end
    run_bus(16'h3000, 1'b1, 1'b0, 8'h00, 1'b0, 8);
    total++;
    if (v_rdy[7:4] !== 4'b1111 || exp_q.size() != 1 || obs_q.size() != 1) begin
      bad++;
      $display("FAIL retry_read: rdy=%b events=%0d required 1111/1", v_rdy[7:4], obs_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.addr !== e.addr || a_dout[7] !== e.data || v_oe[7:5] !== 3'b111) begin
        bad++;
        $display("FAIL retry_read: addr=%h dout=%h oe=%b required %h/%h/111",
                 o.addr, a_dout[7], v_oe[7:5], e.addr, e.data);
      end
    end
    run_bus(16'h3100, 1'b0, 1'b0, 8'h11, 1'b1, 9);
    total++;
    if (v_rdy[7:4] !== 4'b1111 || exp_q.size() != 1 || obs_q.size() != 1) begin
      bad++;
      $display("FAIL wait_write: rdy=%b events=%0d required 1111/1", v_rdy[7:4], obs_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e || v_wr[8] !== 1'b1) begin
        bad++;
        $display("FAIL wait_write: wr=%b addr=%h data=%h required %b/%h/%h",
                 o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
  endtask

  task automatic test_sync_reset();
    run_bus(16'hC000, 1'b1, 1'b1, 8'h00, 1'b0, 8);
    total++;
    if (a_sync[7] !== 16'h0000 || a_sync[8] !== 16'hC000) begin
      bad++;
      $display("FAIL sync_addr: before=%h after=%h required 0000/C000", a_sync[7], a_sync[8]);
    end
    run_bus(16'h4000, 1'b0, 1'b0, 8'h77, 1'b0, 5);
    reset = 1'b1;
    bbc_rnw = 1'b1;
    host_wait = 1'b1;
    exp_q.delete();
    step();
    total++;
    if ({bbc_phi0, rdy, bbc_d_oe, mem_rd, mem_wr, slow_cycle} !== 6'b010000 ||
        {mem_addr, bbc_d_out, mem_wdata, sync_addr} !== 48'h0) begin
      bad++;
      $display("FAIL midreset: ctrl=%b addr=%h dout=%h wdata=%h sync=%h required 010000/0/0/0/0",
               {bbc_phi0, rdy, bbc_d_oe, mem_rd, mem_wr, slow_cycle},
               mem_addr, bbc_d_out, mem_wdata, sync_addr);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL midreset_nowr: memory events=%0d required 0", obs_q.size());
    end
  endtask

  initial begin
    mem[16'h1234] = 8'hA5;
    mem[16'hFC00] = 8'hC3;
    mem[16'hFEFF] = 8'h3C;
    mem[16'hFF00] = 8'h99;
    mem[16'h3000] = 8'h7E;
    mem[16'hC000] = 8'hEA;
    test_reset();
    test_read();
    test_write();
    test_slow_window();
    test_wait();
    test_sync_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
